id_ex_buffer: RTL and testbench

ID_EX_BUFFER -- requirements
Module: id_ex_buffer

---
 rtl/id_ex_buffer_pkg.sv | 21 ++
 rtl/id_ex_buffer_if.sv | 40 ++++
 rtl/redir_hold.sv | 60 ++++++
 rtl/id_ex_buffer.sv | 84 ++++++++
 tb/tb_id_ex_buffer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_buffer_pkg.sv
// Shared types for the decode->execute buffer: the decoded bundle layout and the redirect holder states.
// The pc fields are word-aligned, so the low two bits are dropped. This makes the bundle exactly 160 bits.
package id_ex_buffer_pkg;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [29:0] pc4;
    logic [29:0] pc;
    logic [31:0] imm;
    logic [31:0] rs2_val;
    logic [31:0] rs1_val;
  } id_ex_bundle_t;

  localparam int unsigned BUNDLE_W = $bits(id_ex_bundle_t);

  typedef enum logic {
    REDIR_IDLE = 1'b0,
    REDIR_PEND = 1'b1
  } redir_state_e;

endpackage

// File: rtl/id_ex_buffer_if.sv
// Decode/execute/redirect handshake bundle for id_ex_buffer.
// The master modport is the pipeline side. The slave modport is the buffer.
interface id_ex_buffer_if #(
  parameter int unsigned PAYLOAD_W = 160,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned DEPTH     = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [PAYLOAD_W-1:0] in_payload_i;
  logic                 flush_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [PAYLOAD_W-1:0] out_payload_o;
  logic                 redir_valid_i;
  logic [PC_W-1:0]      redir_pc_i;
  logic                 redir_valid_o;
  logic [PC_W-1:0]      redir_pc_o;
  logic                 redir_ack_i;
  logic [CNT_W-1:0]     count_o;
  logic                 full_o;
  logic                 empty_o;

  modport master (
    output in_valid_i, in_payload_i, flush_i, out_ready_i,
           redir_valid_i, redir_pc_i, redir_ack_i,
    input  in_ready_o, out_valid_o, out_payload_o,
           redir_valid_o, redir_pc_o, count_o, full_o, empty_o
  );

  modport slave (
    input  in_valid_i, in_payload_i, flush_i, out_ready_i,
           redir_valid_i, redir_pc_i, redir_ack_i,
    output in_ready_o, out_valid_o, out_payload_o,
           redir_valid_o, redir_pc_o, count_o, full_o, empty_o
  );

endinterface

// File: rtl/redir_hold.sv
// Single-entry redirect holder. The pending target is visible one cycle after the request.
// It holds until fetch acks. A request that arrives together with the ack replaces the old target.
module redir_hold
  import id_ex_buffer_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redir_valid_i,
  input  logic [PC_W-1:0] redir_pc_i,
  input  logic            redir_ack_i,
  output logic            redir_valid_o,
  output logic [PC_W-1:0] redir_pc_o
);

  redir_state_e    state_q, state_d;
  logic            capture;
  logic [PC_W-1:0] pc_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= REDIR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // First request wins while pending; only an ack in the same cycle opens the slot again.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      REDIR_IDLE: begin
        if (redir_valid_i) begin
          state_d = REDIR_PEND;
          capture = 1'b1;
        end
      end
      REDIR_PEND: begin
        if (redir_ack_i) begin
          capture = redir_valid_i;
          state_d = redir_valid_i ? REDIR_PEND : REDIR_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= '0;
    end else if (capture) begin
      pc_q <= redir_pc_i;
    end
  end

  assign redir_valid_o = (state_q == REDIR_PEND);
  assign redir_pc_o    = pc_q;

endmodule

// File: rtl/id_ex_buffer.sv
// Circular ID/EX skid buffer with flush and a side redirect holder. Output is registered, or same-cycle when BYPASS and empty.
// in_ready_o asserts when the buffer is not full or a pop happens the same cycle. Flush squashes every held and incoming bundle.
module id_ex_buffer
  import id_ex_buffer_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = BUNDLE_W,
  parameter int unsigned DEPTH     = 2,
  parameter bit          BYPASS    = 1'b0,
  parameter int unsigned PC_W      = 32
) (
  input logic           clk_i,
  input logic           rst_ni,
  id_ex_buffer_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 empty, full, byp_path;
  logic                 out_valid, out_fire, in_ready, push, pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign byp_path = BYPASS && empty;

  always_comb begin
    out_valid = 1'b0;
    if (!bus.flush_i) begin
      out_valid = empty ? (byp_path & bus.in_valid_i) : 1'b1;
    end
  end

  assign out_fire = out_valid & bus.out_ready_i;
  assign pop      = out_fire & ~empty;
  assign in_ready = bus.flush_i | ~full | out_fire;
  // A bypassed beat consumed straight away by execute never touches storage.
  assign push     = bus.in_valid_i & in_ready & ~bus.flush_i
                  & ~(byp_path & bus.out_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push != pop) begin
        count <= push ? count + CNT_W'(1) : count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= bus.in_payload_i;
  end

  assign bus.in_ready_o    = in_ready;
  assign bus.out_valid_o   = out_valid;
  assign bus.out_payload_o = byp_path ? bus.in_payload_i : mem[rd_ptr];
  assign bus.count_o       = count;
  assign bus.full_o        = full;
  assign bus.empty_o       = empty;

  redir_hold #(
    .PC_W (PC_W)
  ) u_redir_hold (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .redir_valid_i (bus.redir_valid_i),
    .redir_pc_i    (bus.redir_pc_i),
    .redir_ack_i   (bus.redir_ack_i),
    .redir_valid_o (bus.redir_valid_o),
    .redir_pc_o    (bus.redir_pc_o)
  );

endmodule

// File: tb/tb_id_ex_buffer.sv
// Bench for id_ex_buffer. It drives a registered instance and a bypass instance with the same stimulus.
// Each instance is checked against a queue-based model of the buffer and redirect rules.
module tb_id_ex_buffer;
  localparam int PW    = 160;
  localparam int DEPTH = 2;

  typedef logic [PW-1:0] pl_t;
  typedef pl_t pl_q_t[$];

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        iv, fl, ordy, rv, rack;
  pl_t         ip;
  logic [31:0] rpc;

  int total = 0;
  int bad   = 0;

  pl_q_t       q0, q1;
  bit          rp;
  logic [31:0] rpcm;

  id_ex_buffer_if #(.PAYLOAD_W(PW), .PC_W(32), .DEPTH(DEPTH)) if0 ();
  id_ex_buffer_if #(.PAYLOAD_W(PW), .PC_W(32), .DEPTH(DEPTH)) if1 ();

  assign if0.in_valid_i    = iv;
  assign if0.in_payload_i  = ip;
  assign if0.flush_i       = fl;
  assign if0.out_ready_i   = ordy;
  assign if0.redir_valid_i = rv;
  assign if0.redir_pc_i    = rpc;
  assign if0.redir_ack_i   = rack;
  assign if1.in_valid_i    = iv;
  assign if1.in_payload_i  = ip;
  assign if1.flush_i       = fl;
  assign if1.out_ready_i   = ordy;
  assign if1.redir_valid_i = rv;
  assign if1.redir_pc_i    = rpc;
  assign if1.redir_ack_i   = rack;

  id_ex_buffer #(.PAYLOAD_W(PW), .DEPTH(DEPTH), .BYPASS(1'b0), .PC_W(32)) dut0 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (if0)
  );

  id_ex_buffer #(.PAYLOAD_W(PW), .DEPTH(DEPTH), .BYPASS(1'b1), .PC_W(32)) dut1 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (if1)
  );

  task automatic chk(input string tag, input pl_t obs, input pl_t exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic pl_t rnd_pl();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic set_in(input logic v, input pl_t p, input logic f, input logic r,
                        input logic rvv, input logic [31:0] rpcv, input logic ra);
    iv = v; ip = p; fl = f; ordy = r; rv = rvv; rpc = rpcv; rack = ra;
  endtask

  task automatic check_one(input string n, input bit byp, input pl_q_t q,
                           input logic ov, input pl_t op, input logic ir,
                           input logic [1:0] cnt, input logic fu, input logic em,
                           input logic rvo, input logic [31:0] rpo);
    bit eov, eir;
    eov = !fl && (q.size() > 0 || (byp && iv));
    eir = fl || q.size() < DEPTH || (eov && ordy);
    chk({n, ".out_valid"}, PW'(ov), PW'(eov));
    if (eov) chk({n, ".out_payload"}, op, (q.size() > 0) ? q[0] : ip);
    chk({n, ".in_ready"}, PW'(ir), PW'(eir));
    chk({n, ".count"}, PW'(cnt), PW'(q.size()));
    chk({n, ".full"}, PW'(fu), PW'(q.size() == DEPTH));
    chk({n, ".empty"}, PW'(em), PW'(q.size() == 0));
    chk({n, ".redir_valid"}, PW'(rvo), PW'(rp));
    if (rp) chk({n, ".redir_pc"}, PW'(rpo), PW'(rpcm));
  endtask

  task automatic upd(input bit byp, inout pl_q_t q);
    bit eov, eir;
    int n;
    n   = q.size();
    eov = !fl && (n > 0 || (byp && iv));
    eir = fl || n < DEPTH || (eov && ordy);
    if (fl) begin
      q.delete();
      return;
    end
    if (eov && ordy && n > 0) void'(q.pop_front());
    if (iv && eir && !(byp && n == 0 && ordy)) q.push_back(ip);
  endtask

  task automatic settle();
    #1;
    check_one("d0", 1'b0, q0, if0.out_valid_o, if0.out_payload_o, if0.in_ready_o,
              if0.count_o, if0.full_o, if0.empty_o, if0.redir_valid_o, if0.redir_pc_o);
    check_one("d1", 1'b1, q1, if1.out_valid_o, if1.out_payload_o, if1.in_ready_o,
              if1.count_o, if1.full_o, if1.empty_o, if1.redir_valid_o, if1.redir_pc_o);
  endtask

  task automatic tick();
    @(posedge clk_i);
    upd(1'b0, q0);
    upd(1'b1, q1);
    if (rv && (!rp || rack)) begin
      rp   = 1'b1;
      rpcm = rpc;
    end else if (rack) begin
      rp = 1'b0;
    end
    @(negedge clk_i);
  endtask

  initial begin
    pl_t pa, pb, pcc, pd, p5a;
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    q0.delete(); q1.delete(); rp = 1'b0; rpcm = 32'h0;
    pa = rnd_pl(); pb = rnd_pl(); pcc = rnd_pl(); pd = rnd_pl();
    p5a = PW'(8'h5A);

    repeat (2) @(negedge clk_i);
    #1;
    chk("rst.count", PW'(if0.count_o), PW'(0));
    chk("rst.empty", PW'(if0.empty_o), PW'(1));
    chk("rst.full", PW'(if0.full_o), PW'(0));
    chk("rst.out_valid", PW'(if1.out_valid_o), PW'(0));
    chk("rst.in_ready", PW'(if0.in_ready_o), PW'(1));
    chk("rst.redir_valid", PW'(if0.redir_valid_o), PW'(0));
    chk("rst.redir_pc", PW'(if0.redir_pc_o), PW'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Fill two, then drain in order.
    set_in(1'b1, pa, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); settle(); tick();
    set_in(1'b1, pb, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); settle(); tick();
    set_in(1'b0, pd, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); settle();
    chk("fill.count", PW'(if0.count_o), PW'(2));
    chk("fill.full", PW'(if0.full_o), PW'(1));
    chk("fill.in_ready", PW'(if0.in_ready_o), PW'(0));
    tick();
    set_in(1'b0, pd, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); settle();
    chk("drain.first", if0.out_payload_o, pa); tick();
    settle(); chk("drain.second", if0.out_payload_o, pb); tick();
    settle(); chk("drain.count", PW'(if0.count_o), PW'(0)); tick();

    // Push and pop at the same time while full.
    set_in(1'b1, pa, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); settle(); tick();
    set_in(1'b1, pb, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); settle(); tick();
    set_in(1'b1, pcc, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); settle();
    chk("swap.in_ready", PW'(if0.in_ready_o), PW'(1));
    chk("swap.pop", if0.out_payload_o, pa); tick();
    set_in(1'b0, pd, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); settle();
    chk("swap.count", PW'(if0.count_o), PW'(2));
    chk("swap.head", if0.out_payload_o, pb); tick();
    settle(); chk("swap.tail", if0.out_payload_o, pcc); tick();
    settle(); chk("swap.empty", PW'(if0.count_o), PW'(0)); tick();

    // Flush while full with an incoming beat.
    set_in(1'b1, pa, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); settle(); tick();
    set_in(1'b1, pb, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); settle(); tick();
    set_in(1'b1, pd, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0); settle();
    chk("flush.out_valid", PW'(if0.out_valid_o), PW'(0));
    chk("flush.in_ready", PW'(if0.in_ready_o), PW'(1)); tick();
    set_in(1'b0, pd, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); settle();
    chk("flush.count", PW'(if0.count_o), PW'(0));
    chk("flush.no_beat", PW'(if0.out_valid_o), PW'(0)); tick();

    // Same-cycle bypass on the BYPASS=1 instance.
    set_in(1'b1, p5a, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); settle();
    chk("byp.valid", PW'(if1.out_valid_o), PW'(1));
    chk("byp.payload", if1.out_payload_o, p5a); tick();
    set_in(1'b0, pd, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); settle();
    chk("byp.count", PW'(if1.count_o), PW'(0));
    set_in(1'b0, pd, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0); settle(); tick();

    // Redirect: first request wins; ack plus new request recaptures.
    set_in(1'b0, pd, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0); settle(); tick();
    set_in(1'b0, pd, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0); settle();
    chk("redir.valid", PW'(if0.redir_valid_o), PW'(1));
    chk("redir.first", PW'(if0.redir_pc_o), PW'(32'h80)); tick();
    set_in(1'b0, pd, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); settle();
    chk("redir.held", PW'(if0.redir_pc_o), PW'(32'h80));
    set_in(1'b0, pd, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1); settle(); tick();
    set_in(1'b0, pd, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); settle();
    chk("redir.recap_valid", PW'(if0.redir_valid_o), PW'(1));
    chk("redir.recap_pc", PW'(if0.redir_pc_o), PW'(32'h200));

    // Asynchronous reset with one held bundle and a pending redirect.
    set_in(1'b1, pa, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); settle(); tick();
    set_in(1'b0, pd, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0); settle();
    chk("prerst.count", PW'(if0.count_o), PW'(1));
    #2 rst_ni = 1'b0;
    #1;
    chk("arst.count", PW'(if0.count_o), PW'(0));
    chk("arst.out_valid", PW'(if0.out_valid_o), PW'(0));
    chk("arst.redir_valid", PW'(if0.redir_valid_o), PW'(0));
    chk("arst.in_ready", PW'(if1.in_ready_o), PW'(1));
    q0.delete(); q1.delete(); rp = 1'b0; rpcm = 32'h0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(9) < 7), rnd_pl(), ($urandom_range(19) == 0),
             ($urandom_range(9) < 6), ($urandom_range(9) == 0), $urandom(),
             ($urandom_range(9) < 3));
      settle();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
